// File: rtl/manchester_serial_tx.sv
// Serial Manchester transmitter: valid/ready word intake, IEEE 802.3 or Thomas line code, programmable half-bit rate.
// Optional preamble (eight 1,0 bits ahead of frames started from idle) enabled by defining MANCH_PREAMBLE_EN.
`timescale 1ns/1ps

module manchester_serial_tx #(
  parameter int          DATA_W       = 8,
  parameter int          HALF_BIT_DIV = 4,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              line_out,
  output logic              line_oe,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 8);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_BIT_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

`ifdef MANCH_PREAMBLE_EN
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(7);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PREAMBLE} state_t;
`else
  typedef enum logic {S_IDLE, S_SEND} state_t;
`endif

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic active, half_end, last, accept, cur_bit;

  always_comb begin
    active   = (state_q != S_IDLE);
    half_end = (div_q == DIV_LAST);
    last     = (state_q == S_SEND) && (cnt_q == BIT_LAST) && phase_q && half_end;
    // rst_n gates in_ready so the upstream never sees a ready during reset.
    in_ready   = rst_n & ena & ((state_q == S_IDLE) | last);
    accept     = in_valid & in_ready;
    frame_done = ena & last;
    line_oe    = active;
    busy       = active;
`ifdef MANCH_PREAMBLE_EN
    if (state_q == S_PREAMBLE) cur_bit = ~cnt_q[0];
    else
`endif
    cur_bit = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];
    // IEEE: first half ~b, second half b; Thomas is the inverse of that.
    line_out = active & (cur_bit ^ mode_q ^ ~phase_q);
  end

  // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    div_d   = div_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (ena) begin
      if (accept) begin
        shreg_d = in_data;
        mode_d  = mode;
        div_d   = '0;
        phase_d = 1'b0;
        cnt_d   = '0;
`ifdef MANCH_PREAMBLE_EN
        state_d = (state_q == S_IDLE) ? S_PREAMBLE : S_SEND;
`else
        state_d = S_SEND;
`endif
      end else if (active && half_end) begin
        div_d   = '0;
        phase_d = ~phase_q;
        if (phase_q) begin
`ifdef MANCH_PREAMBLE_EN
          if (state_q == S_PREAMBLE) begin
            if (cnt_q == PRE_LAST) begin
              cnt_d   = '0;
              state_d = S_SEND;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else
`endif
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end
      end else if (active) begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      mode_q  <= 1'b0;
      div_q   <= '0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_manchester_serial_tx.sv
// Self-checking bench for manchester_serial_tx: MSB-first and LSB-first instances share stimulus; a per-cycle scoreboard checks both lines.
`timescale 1ns/1ps

module tb_manchester_serial_tx;

  localparam int DW  = 8;
  localparam int DIV = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;

  logic ready_m, line_m, oe_m, busy_m, done_m;
  logic ready_l, line_l, oe_l, busy_l, done_l;

  always #5 clk = ~clk;

  manchester_serial_tx #(.DATA_W(DW), .HALF_BIT_DIV(DIV), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_m), .line_out(line_m), .line_oe(oe_m), .busy(busy_m), .frame_done(done_m)
  );

  manchester_serial_tx #(.DATA_W(DW), .HALF_BIT_DIV(DIV), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_l), .line_out(line_l), .line_oe(oe_l), .busy(busy_l), .frame_done(done_l)
  );

  typedef struct packed {
    logic line_m;
    logic line_l;
    logic fd;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          mode;
    logic [15:0]   halves_m;  // first transmitted half-bit in bit 15
    logic [15:0]   halves_l;
  } vec_t;

  exp_t sb[$];
  exp_t e_cur = '0;
  logic prev_ena = 1'b0;
  int   oe_run = 0;
  int   max_run = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Each active cycle consumes one entry, unless the previous cycle was stalled, in which case the same entry repeats.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outs", {line_m, oe_m, busy_m, done_m, ready_m, line_l, oe_l, done_l, ready_l}, 0);
      prev_ena = 1'b0;
      oe_run   = 0;
    end else if (oe_m) begin
      if (prev_ena) begin
        if (sb.size() == 0) check("extra_active_cycle", 1, 0);
        else e_cur = sb.pop_front();
      end
      check("line_msb", line_m, e_cur.line_m);
      check("line_lsb", line_l, e_cur.line_l);
      check("frame_done", {done_m, done_l}, {2{e_cur.fd & ena}});
      check("in_ready_send", {ready_m, ready_l}, {2{e_cur.fd & ena}});
      check("active_flags", {busy_m, oe_l, busy_l}, 3'b111);
      oe_run++;
      if (oe_run > max_run) max_run = oe_run;
      prev_ena = ena;
    end else begin
      check("idle_outs", {line_m, busy_m, done_m, line_l, oe_l, busy_l, done_l}, 0);
      check("in_ready_idle", {ready_m, ready_l}, {2{ena}});
      oe_run   = 0;
      prev_ena = ena;
    end
  end

  task automatic push_frame(input logic [15:0] hm, input logic [15:0] hl);
    for (int h = 0; h < 16; h++)
      for (int d = 0; d < DIV; d++)
        sb.push_back('{line_m: hm[15-h], line_l: hl[15-h], fd: (h == 15 && d == DIV - 1)});
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [DW-1:0] d, input logic m, input logic [15:0] hm,
                      input logic [15:0] hl, input bit hold_valid);
    bit ok = 0;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ready_m) begin
        push_frame(hm, hl);
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", ok, 1);
    if (!hold_valid) in_valid = 1'b0;
    // Disturb the inputs: the frame in flight must use the latched word and mode.
    in_data = ~d;
    mode    = ~m;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (sb.size() == 0 && !oe_m) begin
        ok = 1;
        break;
      end
    end
    check("drain_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 16'h6699, 16'h6699};
    vecs[1] = '{8'hA5, 1'b1, 16'h9966, 16'h9966};
    vecs[2] = '{8'h01, 1'b0, 16'hAAA9, 16'h6AAA};
    vecs[3] = '{8'hFF, 1'b0, 16'h5555, 16'h5555};
    vecs[4] = '{8'h00, 1'b0, 16'hAAAA, 16'hAAAA};
    vecs[5] = '{8'h0F, 1'b1, 16'h55AA, 16'hAA55};

    #3;
    check("reset_state", {line_m, oe_m, busy_m, done_m, ready_m}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("ready_after_reset", ready_m, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      max_run = 0;
      send(vecs[i].data, vecs[i].mode, vecs[i].halves_m, vecs[i].halves_l, 0);
      wait_idle();
      check($sformatf("oe_len_vec%0d", i), max_run, 2 * DW * DIV);
    end

    // Back-to-back: second word waits with valid held high and is taken in the frame_done cycle.
    max_run = 0;
    send(8'hFF, 1'b0, 16'h5555, 16'h5555, 1);
    send(8'h00, 1'b0, 16'hAAAA, 16'hAAAA, 0);
    wait_idle();
    check("b2b_oe_len", max_run, 4 * DW * DIV);

    // Five-cycle stall mid-frame stretches the frame by exactly five cycles.
    max_run = 0;
    send(8'hA5, 1'b0, 16'h6699, 16'h6699, 0);
    repeat (9) @(posedge clk);
    #1 ena = 1'b0;
    repeat (5) @(posedge clk);
    #1 ena = 1'b1;
    wait_idle();
    check("stall_oe_len", max_run, 2 * DW * DIV + 5);

    // Reset pulse during bit 3 aborts the frame at once.
    send(8'hA5, 1'b0, 16'h6699, 16'h6699, 0);
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1 check("abort_outs", {line_m, oe_m, busy_m, done_m, ready_m}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("ready_after_abort", ready_m, 1);
    @(posedge clk); #1;
    max_run = 0;
    send(vecs[0].data, vecs[0].mode, vecs[0].halves_m, vecs[0].halves_l, 0);
    wait_idle();
    check("recover_oe_len", max_run, 2 * DW * DIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/manchester_serial_tx.md
Name: manchester_serial_tx

Overview:
- Parametrised serial Manchester transmitter; next generation of the parallel 8-to-16-bit Manchester encoder.
- Accepts DATA_W-bit words over a valid/ready handshake and serialises them onto one line at a programmable half-bit rate.
- Per-frame IEEE 802.3 or G.E. Thomas convention, selectable bit order, seamless back-to-back frames.
- Sits between a TT top wrapper (ui_in/uio pins) and an output pin driving the physical line.

Parameters:
- DATA_W, 8: bits per frame; must be >= 1.
- HALF_BIT_DIV, 4: clk cycles per half-bit; must be >= 1.
- MSB_FIRST, 1: 1 = transmit bit DATA_W-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; low stalls the block.
- mode  input  1  0 = IEEE 802.3, 1 = Thomas; sampled at frame acceptance.
- in_data  input  DATA_W  word to send.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- line_out  output  1  encoded serial line.
- line_oe  output  1  line driver enable; high only while a frame is on the line.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse in the final cycle of a frame.

Behaviour:
- Reset (async assert, sync release): state IDLE; line_out=0, line_oe=0, busy=0, frame_done=0, in_ready=0 while rst_n low; shift register, divider and bit counter cleared.
- States: IDLE and SEND (PREAMBLE added under the optional feature).
- IDLE:
  - in_ready = ena.
  - Handshake = in_valid & in_ready at a rising edge: latch in_data and mode, go to SEND.
  - Output of the first half-bit starts on the next cycle.
- Encoding, per bit b:
  - IEEE (mode 0): first half = ~b, second half = b (1 = low-to-high).
  - Thomas (mode 1): first half = b, second half = ~b.
- Timing:
  - Each half-bit is held exactly HALF_BIT_DIV cycles.
  - A frame occupies 2*DATA_W*HALF_BIT_DIV cycles.
  - Half-bit divider counts 0..HALF_BIT_DIV-1, then toggles the phase. After the second phase, the next bit is shifted in per MSB_FIRST.
- SEND: line_oe=1, busy=1.
- Last cycle of a frame (last bit, second half, divider = HALF_BIT_DIV-1):
  - frame_done=1.
  - in_ready = ena.
  - If a handshake occurs in that cycle, the new word and mode are loaded and its first half-bit begins next cycle with no gap; line_oe stays 1 and state stays SEND.
  - Otherwise go to IDLE next cycle: line_out=0, line_oe=0.
- in_ready is 0 in all other SEND cycles. in_valid without ready is ignored; in_data need not be held.
- ena low during SEND: divider, phase, shift register and counter freeze; line_out/line_oe hold their values; frame_done suppressed. Resumes exactly where stopped.
- mode changes mid-frame have no effect until the next acceptance.
- rst_n asserted mid-frame: frame aborted immediately, outputs forced to reset values, no frame_done.

Optional Feature:
- Macro: MANCH_PREAMBLE_EN.
- Defined:
  - Each frame accepted from IDLE is preceded by PREAMBLE state: 8 bits of pattern 1,0,1,0,1,0,1,0, encoded with the latched mode at the same half-bit rate.
  - Frame length becomes 2*(DATA_W+8)*HALF_BIT_DIV cycles; frame_done still marks the end of the data bits.
  - Back-to-back frames accepted in the final cycle skip the preamble.
- Not defined: no PREAMBLE state; data starts immediately.

Test Plan:
- DATA_W=8, DIV=2, MSB_FIRST=1, IEEE, send 0xA5 -> line_out half-bits 01 10 01 10 10 01 10 01, each held 2 cycles; line_oe high for 32 cycles; frame_done in cycle 32; then line_out=0, line_oe=0.
- Same word, mode=1 (Thomas) -> every half-bit inverted: 10 01 10 01 01 10 01 10.
- MSB_FIRST=0, IEEE, 0x01 -> first bit sent is 1 (half-bits 0 then 1), followed by seven 0 bits (1 then 0).
- 0xFF then 0x00 presented with in_valid held high -> second frame accepted in the frame_done cycle; line_oe stays high with no idle cycle for 64 cycles total.
- ena low for 5 cycles mid-frame -> line_out frozen; frame stretched by exactly 5 cycles; bit sequence unchanged.
- rst_n pulsed low during bit 3 -> line_out=0, line_oe=0, busy=0 immediately; no frame_done; in_ready=1 after release with ena=1.
